// File: rtl/uart_echo_fifo_if.sv
// Receive/transmit handshake bundle between the UART core and the echo FIFO.
// The master side is the UART core; the slave side is the echo FIFO.
interface uart_echo_fifo_if #(
  parameter int WIDTH = 8
);
  logic             rx_done;
  logic [WIDTH-1:0] rx_data;
  logic             rx_err;
  logic             tx_done;
  logic             frame_en;
  logic [WIDTH-1:0] data_frame;

  modport master (
    output rx_done, rx_data, rx_err, tx_done,
    input  frame_en, data_frame
  );

  modport slave (
    input  rx_done, rx_data, rx_err, tx_done,
    output frame_en, data_frame
  );
endinterface

// File: rtl/uart_echo_fifo.sv
// UART echo buffer: received frames are queued in a register FIFO and replayed
// to the transmitter one at a time, with overflow and line-error counters.
module uart_echo_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     rst,
  uart_echo_fifo_if.slave          bus,
  input  logic                     drop_err,
  input  logic                     tx_pause,
  input  logic                     clr_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic                     almost_full,
  output logic [7:0]               ovf_cnt,
  output logic [7:0]               err_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} tx_state_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  tx_state_t        state;
  logic             pop, storable, push, ovf_inc, err_inc;

  assign fifo_level  = wr_ptr - rd_ptr;
  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_full   = (fifo_level == LW'(DEPTH));
  assign almost_full = (fifo_level >= LW'(AFULL_TH));

  // A full FIFO still takes a frame when the head leaves in the same cycle.
  assign pop      = (state == IDLE) && !fifo_empty && !tx_pause;
  assign storable = bus.rx_done && !(bus.rx_err && drop_err);
  assign push     = storable && (!fifo_full || pop);
  assign ovf_inc  = storable && fifo_full && !pop;
  assign err_inc  = bus.rx_done && bus.rx_err;

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr[AW-1:0]] <= bus.rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // On a full-FIFO push+pop both hit the same slot; the read sees the old head.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bus.frame_en   <= 1'b0;
      bus.data_frame <= '0;
    end else begin
      bus.frame_en <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            bus.data_frame <= mem[rd_ptr[AW-1:0]];
            bus.frame_en   <= 1'b1;
            state          <= LAUNCH;
          end
        end
        LAUNCH:  state <= WAIT;
        WAIT:    if (bus.tx_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      ovf_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (ovf_inc && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
      if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_uart_echo_fifo.sv
// Bench for uart_echo_fifo: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_uart_echo_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AFULL_TH = 14;
  localparam int LW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic rx_done = 0, rx_err = 0, drop_err = 0, tx_pause = 0, clr_cnt = 0;
  logic tx_done_stim = 0, tx_done_auto = 0, auto_tx = 0, cmp_en = 0;
  logic [7:0] rx_data = 0;
  logic [LW-1:0] fifo_level;
  logic fifo_full, fifo_empty, almost_full;
  logic [7:0] ovf_cnt, err_cnt;

  uart_echo_fifo_if #(.WIDTH(WIDTH)) bus();
  assign bus.rx_done = rx_done;
  assign bus.rx_data = rx_data;
  assign bus.rx_err  = rx_err;
  assign bus.tx_done = tx_done_stim | tx_done_auto;

  uart_echo_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .drop_err(drop_err), .tx_pause(tx_pause),
    .clr_cnt(clr_cnt), .fifo_level(fifo_level), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .almost_full(almost_full), .ovf_cnt(ovf_cnt),
    .err_cnt(err_cnt)
  );

  int checks = 0, errors = 0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of stored frames, transmitter phase 0=idle 1=start 2=busy.
  logic [7:0] mq[$];
  int phase = 0, m_frame = 0, m_ovf = 0, m_err = 0;
  always @(posedge clk) begin : model
    int full, pop_now, st, ovf_inc, err_inc;
    if (rst) begin
      mq.delete();
      phase = 0; m_frame = 0; m_ovf = 0; m_err = 0;
    end else begin
      full    = (mq.size() == DEPTH);
      pop_now = (phase == 0) && (mq.size() > 0) && !tx_pause;
      st      = rx_done && !(rx_err && drop_err);
      ovf_inc = st && full && !pop_now;
      err_inc = rx_done && rx_err;
      if (phase == 1) phase = 2;
      else if (phase == 2 && (tx_done_stim | tx_done_auto)) phase = 0;
      if (pop_now) begin
        m_frame = mq.pop_front();
        phase = 1;
      end
      if (st && (!full || pop_now)) mq.push_back(rx_data);
      if (clr_cnt) begin
        m_ovf = 0; m_err = 0;
      end else begin
        if (ovf_inc && m_ovf < 255) m_ovf++;
        if (err_inc && m_err < 255) m_err++;
      end
    end
  end

  logic [7:0] sent[$];
  always @(negedge clk) begin
    if (bus.frame_en) sent.push_back(bus.data_frame);
    if (cmp_en) begin
      chk("frame_en", bus.frame_en, phase == 1);
      chk("data_frame", bus.data_frame, m_frame);
      chk("fifo_level", fifo_level, mq.size());
      chk("fifo_full", fifo_full, mq.size() == DEPTH);
      chk("fifo_empty", fifo_empty, mq.size() == 0);
      chk("almost_full", almost_full, mq.size() >= AFULL_TH);
      chk("ovf_cnt", ovf_cnt, m_ovf);
      chk("err_cnt", err_cnt, m_err);
    end
  end

  // Transmitter stand-in: completes a frame 1..4 cycles after its start strobe.
  int dly = 0;
  always @(negedge clk) begin
    tx_done_auto = 1'b0;
    if (auto_tx) begin
      if (dly > 0) begin
        dly--;
        if (dly == 0) tx_done_auto = 1'b1;
      end else if (bus.frame_en) begin
        dly = $urandom_range(1, 4);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; rx_done = 1; rx_data = 8'h77; tx_done_stim = 0;
    cyc(); cyc();
    rst = 0; rx_done = 0; rx_err = 0; drop_err = 0; tx_pause = 0; clr_cnt = 0;
    sent.delete();
  endtask

  task automatic send(input logic [7:0] d, input logic e);
    rx_done = 1; rx_data = d; rx_err = e;
    cyc();
    rx_done = 0; rx_err = 0;
  endtask

  task automatic wait_sent(input int n, input int budget);
    int k = 0;
    while (sent.size() < n && k < budget) begin cyc(); k++; end
    chk("wait_sent", sent.size(), n);
  endtask

  initial begin
    cyc();
    do_reset();
    cmp_en = 1;
    chk("rst_level", fifo_level, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_data_frame", bus.data_frame, 0);
    chk("rst_ignores_rx", ovf_cnt + err_cnt, 0);

    // Single frame latency and completion.
    send(8'h5A, 0);
    chk("lat_n1_fe", bus.frame_en, 0);
    cyc();
    chk("lat_n2_fe", bus.frame_en, 1);
    chk("lat_n2_data", bus.data_frame, 8'h5A);
    cyc();
    chk("lat_n3_fe", bus.frame_en, 0);
    repeat (9) cyc();
    tx_done_stim = 1; cyc(); tx_done_stim = 0;
    chk("lat_empty", fifo_empty, 1);
    chk("lat_sent", sent.size(), 1);
    send(8'h3C, 0); cyc();
    chk("idle_again_fe", bus.frame_en, 1);
    tx_done_stim = 1; cyc(); tx_done_stim = 0;

    // Paused fill with one overflow, then in-order drain.
    do_reset();
    tx_pause = 1;
    for (int i = 0; i < 17; i++) begin
      send(8'(i), 0);
      chk("fill_level", fifo_level, (i + 1 > 16) ? 16 : i + 1);
      chk("fill_afull", almost_full, (i + 1) >= 14);
    end
    chk("fill_full", fifo_full, 1);
    chk("fill_ovf", ovf_cnt, 1);
    auto_tx = 1; tx_pause = 0;
    wait_sent(16, 300);
    repeat (20) cyc();
    chk("drain_count", sent.size(), 16);
    for (int i = 0; i < 16 && i < sent.size(); i++) chk("drain_order", sent[i], i);

    // Errored frames: dropped, then kept.
    do_reset();
    drop_err = 1;
    send(8'hFF, 1);
    repeat (4) cyc();
    chk("drop_level", fifo_level, 0);
    chk("drop_sent", sent.size(), 0);
    chk("drop_err_cnt", err_cnt, 1);
    drop_err = 0;
    send(8'hFF, 1);
    wait_sent(1, 50);
    if (sent.size() > 0) chk("keep_data", sent[0], 8'hFF);
    chk("keep_err_cnt", err_cnt, 2);
    chk("keep_ovf_cnt", ovf_cnt, 0);

    // Push into a full FIFO in the pop cycle.
    do_reset();
    tx_pause = 1;
    for (int i = 0; i < 16; i++) send(8'(8'h20 + i), 0);
    chk("pp_full", fifo_full, 1);
    tx_pause = 0;
    send(8'hA5, 0);
    chk("pp_level", fifo_level, 16);
    chk("pp_ovf", ovf_cnt, 0);
    wait_sent(17, 400);
    if (sent.size() == 17) begin
      chk("pp_first", sent[0], 8'h20);
      chk("pp_last", sent[16], 8'hA5);
    end

    // Reset while a frame is in flight with five queued.
    do_reset();
    auto_tx = 0;
    for (int i = 0; i < 6; i++) send(8'(8'h40 + i), 0);
    repeat (2) cyc();
    chk("wait_level", fifo_level, 5);
    rst = 1; rx_done = 1; cyc(); rst = 0; rx_done = 0;
    chk("rstw_fe", bus.frame_en, 0);
    chk("rstw_level", fifo_level, 0);
    sent.delete();
    tx_done_stim = 1; cyc(); tx_done_stim = 0;
    repeat (4) cyc();
    chk("rstw_no_tx", sent.size(), 0);

    // Overflow saturation and clear priority.
    do_reset();
    tx_pause = 1;
    for (int i = 0; i < 16; i++) send(8'(i), 0);
    for (int i = 0; i < 300; i++) send(8'(i), 0);
    chk("sat_ovf", ovf_cnt, 255);
    rx_done = 1; clr_cnt = 1; cyc(); rx_done = 0; clr_cnt = 0;
    chk("clr_wins", ovf_cnt, 0);
    send(8'h11, 0);
    chk("after_clr", ovf_cnt, 1);

    // Randomized soak against the model.
    do_reset();
    auto_tx = 1;
    for (int c = 0; c < 4000; c++) begin
      rx_done  = ($urandom_range(0, 2) == 0);
      rx_data  = 8'($urandom);
      rx_err   = ($urandom_range(0, 7) == 0);
      clr_cnt  = ($urandom_range(0, 299) == 0);
      rst      = ($urandom_range(0, 699) == 0);
      tx_done_stim = ($urandom_range(0, 15) == 0);
      if (c % 200 == 0) drop_err = $urandom_range(0, 1);
      if ($urandom_range(0, 39) == 0) tx_pause = ~tx_pause;
      cyc();
    end
    rx_done = 0; rx_err = 0; clr_cnt = 0; rst = 0; tx_done_stim = 0; tx_pause = 0;
    repeat (200) cyc();
    chk("soak_drained", fifo_empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_echo_fifo.md
UART_ECHO_FIFO -- requirements
Module: uart_echo_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per frame.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO entries; power of 2, at least 4.
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-2, almost-full threshold in entries.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port rx_done, input, 1, one-cycle strobe, received frame valid.
REQ-007 SHALL have port rx_data, input, WIDTH, received frame; valid with rx_done.
REQ-008 SHALL have port rx_err, input, 1, parity/stop error flag; valid with rx_done.
REQ-009 SHALL have port drop_err, input, 1, mode: 1 = discard errored frames.
REQ-010 SHALL have port tx_pause, input, 1, mode: 1 = hold transmission start.
REQ-011 SHALL have port frame_en, output, 1, one-cycle transmitter start strobe.
REQ-012 SHALL have port data_frame, output, WIDTH, frame to transmitter.
REQ-013 SHALL have port tx_done, input, 1, one-cycle transmitter completion strobe.
REQ-014 SHALL have port clr_cnt, input, 1, synchronous clear of both counters.
REQ-015 SHALL have port fifo_level, output, $clog2(DEPTH)+1, occupied entries.
REQ-016 SHALL have port fifo_full, output, 1, level == DEPTH.
REQ-017 SHALL have port fifo_empty, output, 1, level == 0.
REQ-018 SHALL have port almost_full, output, 1, level >= AFULL_TH; RTS source.
REQ-019 SHALL have port ovf_cnt, output, 8, frames lost to overflow; saturating.
REQ-020 SHALL have port err_cnt, output, 8, frames seen with rx_err; saturating.

Function
REQ-021 SHALL use an internal register-array FIFO with wr/rd pointers wrapping modulo DEPTH; level equals the wr-rd difference, with the extra bit distinguishing full from empty.
REQ-022 SHALL, on rx_done with rx_err=1 and drop_err=1, discard the frame, increment err_cnt, and leave ovf_cnt unchanged.
REQ-023 SHALL, on rx_done with rx_err=1 and drop_err=0, store the frame normally and increment err_cnt.
REQ-024 SHALL accept a storable frame when level<DEPTH, or when full and a pop occurs in the same cycle (level unchanged); otherwise it SHALL discard the frame and increment ovf_cnt.
REQ-025 SHALL derive fifo_full, fifo_empty, almost_full and fifo_level from registered pointers, updated the cycle after the write/pop edge.
REQ-026 SHALL implement a TX FSM with states IDLE, LAUNCH and WAIT.
REQ-027 SHALL, in IDLE with fifo_empty=0 and tx_pause=0, pop the head into the data_frame register and move to LAUNCH.
REQ-028 SHALL, in LAUNCH, assert frame_en for exactly one cycle and then move to WAIT.
REQ-029 SHALL, in WAIT, return to IDLE on tx_done; tx_done in IDLE or LAUNCH SHALL be ignored.
REQ-030 SHALL hold data_frame stable from pop until the next pop.
REQ-031 SHALL sample tx_pause only in IDLE; a frame in LAUNCH/WAIT completes regardless.
REQ-032 SHALL give a latency of 2 cycles from an rx_done cycle N on an empty idle block to frame_en in cycle N+2; back-to-back frames SHALL be separated by at least 1 IDLE cycle after tx_done.
REQ-033 SHALL preserve strict FIFO order; dropped frames leave no gap.
REQ-034 SHALL saturate both counters at 255; when clr_cnt coincides with an increment, the clear SHALL win.

Reset
REQ-035 SHALL, with rst=1 at a clk edge: pointers=0, fifo_level=0, fifo_empty=1, fifo_full=0, almost_full=0, frame_en=0, data_frame=0, ovf_cnt=0, err_cnt=0, FSM=IDLE.
REQ-036 SHALL ignore rx_done and tx_done while rst=1, abandon any in-flight frame, and discard queued data.

Verification
REQ-037 SHALL cover: rx_done with 0x5A at cycle N on an empty idle block -> frame_en high only in cycle N+2 with data_frame=0x5A; tx_done at N+12 -> IDLE, fifo_empty=1.
REQ-038 SHALL cover: tx_pause=1, 17 frames 0x00..0x10 -> level=16, fifo_full=1, almost_full set from level 14, ovf_cnt=1; release pause -> 0x00..0x0F sent in order, 0x10 never sent.
REQ-039 SHALL cover: drop_err=1 with rx_err=1 and 0xFF -> not stored, err_cnt=1; repeat with drop_err=0 -> stored and sent, err_cnt=2, ovf_cnt=0.
REQ-040 SHALL cover: FIFO full, IDLE, tx_pause falling, rx_done with 0xA5 in the pop cycle -> accepted, level stays 16, ovf_cnt unchanged, 0xA5 sent last.
REQ-041 SHALL cover: rst in WAIT with 5 queued -> frame_en=0 and level=0 after reset; a later tx_done causes no frame_en.
REQ-042 SHALL cover: 300 overflows -> ovf_cnt=255; clr_cnt coincident with an overflow -> ovf_cnt=0 next cycle.
